// File: rtl/panel_pkg.sv
// Shared constants, pixel/row types and receiver FSM states for the RGB panel receiver.
package panel_pkg;

    localparam int COLS        = 32;
    localparam int ROW_BITS    = 3;
    localparam int NUM_ROWS    = 2 * (2 ** ROW_BITS);
    localparam int SYNC_STAGES = 2;
    localparam int CNT_BITS    = 6;

    typedef logic [2:0]       rgb_t;
    typedef rgb_t [COLS-1:0]  row_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } rx_state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] value);
        return (value == {CNT_BITS{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/panel_receiver_edge_sync.sv
// Multi-flop synchronizer with a rising-edge pulse taken off the last stage.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   level_d_reg;

    // Shift the asynchronous input through the synchronizer chain and keep
    // one extra copy of the synchronized level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg    <= '0;
            level_d_reg <= 1'b0;
        end else begin
            sync_reg[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            level_d_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = sync_reg[SYNC_STAGES-1] & ~level_d_reg;

endmodule

// File: rtl/panel_receiver.sv
// Receiving end of the RGB matrix shift/latch interface: synchronizes the
// serial stream, shifts column data and commits rows into a frame buffer.
module panel_receiver
    import panel_pkg::*;
#(
    parameter int COLS        = panel_pkg::COLS,
    parameter int ROW_BITS    = panel_pkg::ROW_BITS,
    parameter int SYNC_STAGES = panel_pkg::SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sclk,
    input  logic                    latch,
    input  logic                    blank,
    input  logic [2:0]              LED_Top,
    input  logic [2:0]              LED_Bottom,
    input  logic [ROW_BITS-1:0]     Row_select,
    input  logic [ROW_BITS:0]       rd_row,
    input  logic [$clog2(COLS)-1:0] rd_col,
    output logic [2:0]              rd_pixel,
    output logic                    row_written,
    output logic [ROW_BITS-1:0]     row_written_addr,
    output logic                    frame_done,
    output logic [5:0]              bit_count,
    output logic                    err_count,
    output logic                    err_unblanked,
    input  logic                    err_clr
);

    localparam int HALF_ROWS = 2 ** ROW_BITS;
    localparam int TOT_ROWS  = 2 * HALF_ROWS;
    localparam int DW        = 3 + 3 + ROW_BITS;

    // Synchronized control strobes
    logic sclk_rise, latch_rise, blank_level;
    logic sclk_level_unused, latch_level_unused, blank_rise_unused;

    // Data delayed to line up with the synchronized strobes
    logic [SYNC_STAGES-1:0][DW-1:0] dly_reg;
    rgb_t                           top_al, bot_al;
    logic [ROW_BITS-1:0]            row_al;

    // Receiver state
    rx_state_t             state_reg, state_next;
    logic                  commit;
    rgb_t [COLS-1:0]       sr_top_reg, sr_bot_reg;
    logic [5:0]            bit_count_reg, bit_count_next, cnt_base;
    logic [ROW_BITS-1:0]   commit_row_reg;
    rgb_t [COLS-1:0]       frame_mem [TOT_ROWS];

    // Status outputs
    rgb_t                  rd_pixel_reg;
    logic                  row_written_reg, frame_done_reg;
    logic [ROW_BITS-1:0]   row_written_addr_reg;
    logic                  err_count_reg, err_unblanked_reg;
    logic                  err_count_set, err_unbl_set;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk   (clk),
        .reset (reset),
        .din   (latch),
        .level (latch_level_unused),
        .rise  (latch_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_blank (
        .clk   (clk),
        .reset (reset),
        .din   (blank),
        .level (blank_level),
        .rise  (blank_rise_unused)
    );

    // Delay pixel data and row address by the synchronizer depth so they are
    // sampled in the same cycle the matching strobe edge is detected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_reg <= '0;
        end else begin
            dly_reg[0] <= {LED_Top, LED_Bottom, Row_select};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dly_reg[i] <= dly_reg[i-1];
            end
        end
    end

    assign top_al = dly_reg[SYNC_STAGES-1][DW-1 -: 3];
    assign bot_al = dly_reg[SYNC_STAGES-1][ROW_BITS+2 -: 3];
    assign row_al = dly_reg[SYNC_STAGES-1][ROW_BITS-1:0];

    assign commit = (state_reg == ST_COMMIT);

    // Next-state logic: a latch edge commits from either IDLE or SHIFT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (latch_rise) begin
                    state_next = ST_COMMIT;
                end else if (sclk_rise) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (latch_rise) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Bit counter: cleared by a commit, then any same-cycle shift counts on top.
    always_comb begin
        cnt_base       = commit ? 6'd0 : bit_count_reg;
        bit_count_next = sclk_rise ? sat_inc(cnt_base) : cnt_base;
    end

    // FSM state, bit counter and the row address captured at the latch edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            bit_count_reg  <= '0;
            commit_row_reg <= '0;
        end else begin
            state_reg     <= state_next;
            bit_count_reg <= bit_count_next;
            if (latch_rise && !commit) begin
                commit_row_reg <= row_al;
            end
        end
    end

    // Column shift registers: new bits enter column 0, so the first bit of a
    // row ends up in column COLS-1 after a full load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_top_reg <= '0;
            sr_bot_reg <= '0;
        end else if (sclk_rise) begin
            sr_top_reg <= {sr_top_reg[COLS-2:0], top_al};
            sr_bot_reg <= {sr_bot_reg[COLS-2:0], bot_al};
        end
    end

    // Frame buffer: commit writes the top half row and its bottom-half twin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TOT_ROWS; i++) begin
                frame_mem[i] <= '0;
            end
        end else if (commit) begin
            frame_mem[{1'b0, commit_row_reg}] <= sr_top_reg;
            frame_mem[{1'b1, commit_row_reg}] <= sr_bot_reg;
        end
    end

    // Registered read port; a read during commit sees the pre-commit contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pixel_reg <= '0;
        end else begin
            rd_pixel_reg <= frame_mem[rd_row][rd_col];
        end
    end

    // Commit notification pulses, registered in the commit cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_written_reg      <= 1'b0;
            row_written_addr_reg <= '0;
            frame_done_reg       <= 1'b0;
        end else begin
            row_written_reg <= commit;
            frame_done_reg  <= commit && (commit_row_reg == ROW_BITS'(HALF_ROWS - 1));
            if (commit) begin
                row_written_addr_reg <= commit_row_reg;
            end
        end
    end

    assign err_count_set = commit && (bit_count_reg != 6'(COLS));
    assign err_unbl_set  = latch_rise && !blank_level;

    // Sticky protocol errors; a set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count_reg     <= 1'b0;
            err_unblanked_reg <= 1'b0;
        end else begin
            if (err_count_set) begin
                err_count_reg <= 1'b1;
            end else if (err_clr) begin
                err_count_reg <= 1'b0;
            end
            if (err_unbl_set) begin
                err_unblanked_reg <= 1'b1;
            end else if (err_clr) begin
                err_unblanked_reg <= 1'b0;
            end
        end
    end

    assign rd_pixel         = rd_pixel_reg;
    assign row_written      = row_written_reg;
    assign row_written_addr = row_written_addr_reg;
    assign frame_done       = frame_done_reg;
    assign bit_count        = bit_count_reg;
    assign err_count        = err_count_reg;
    assign err_unblanked    = err_unblanked_reg;

endmodule

// File: doc/panel_receiver.md
Name: panel_receiver

Overview:
- Receiving end of the RGB matrix shift/latch interface (sclk, latch, blank, LED_Top, LED_Bottom, Row_select).
- Behaves as a synthesizable model of the 16x32 panel: samples the serial stream on the system clock, shifts column data, and commits a row into a frame buffer on latch.
- Exposes a read port plus protocol-error flags for on-chip self-check and simulation scoreboarding.

Parameters:
COLS, 32, columns per row (shift-register length)
ROW_BITS, 3, Row_select width; panel has 2*2^ROW_BITS rows
SYNC_STAGES, 2, synchronizer depth on sclk/latch/blank

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sclk  in  1  serial shift clock from driver
latch  in  1  row latch strobe
blank  in  1  display blank (1 = blanked)
LED_Top  in  3  RGB bit for top-half row
LED_Bottom  in  3  RGB bit for bottom-half row
Row_select  in  ROW_BITS  row address
rd_row  in  ROW_BITS+1  read row; MSB=1 selects bottom half
rd_col  in  5  read column (clog2(COLS))
rd_pixel  out  3  RGB at rd_row/rd_col
row_written  out  1  one-cycle pulse after a row commit
row_written_addr  out  ROW_BITS  Row_select of last commit
frame_done  out  1  one-cycle pulse when row 2^ROW_BITS-1 is committed
bit_count  out  6  sclk edges since last latch, saturating at 63
err_count  out  1  sticky: latch with bit_count != COLS
err_unblanked  out  1  sticky: latch while blank=0
err_clr  in  1  synchronous clear of both sticky errors

Behaviour:
- Reset (reset=0, async): all outputs 0; shift registers, synchronizers, bit_count, and frame buffer cleared to 0; FSM to IDLE.
- sclk/latch/blank pass through SYNC_STAGES flops, then rising-edge detect. LED_Top/LED_Bottom/Row_select are delayed by the same number of stages so data aligns with the detected edge.
- Input requirement: each level held >= SYNC_STAGES+1 clk cycles. Shorter pulses are unsupported.
- sclk rising edge: the top and bottom shift registers shift in the aligned LED bits; bit_count increments (saturates at 63).
- Bit ordering: the k-th bit after a latch (k from 0) lands at column COLS-1-k once COLS bits have been shifted. With more than COLS shifts, the oldest bits fall off.
- FSM states:
  - IDLE: bit_count=0; sclk edge -> SHIFT.
  - SHIFT: latch edge -> COMMIT.
  - COMMIT: 1 cycle; writes both shift registers into frame rows r and r+2^ROW_BITS (r = aligned Row_select); bit_count cleared; next state IDLE.
  - Latch edge in IDLE also goes to COMMIT (zero-bit commit, err_count set).
- Same-cycle sclk and latch edges: the shift happens first, and the commit uses the post-shift contents and count.
- sclk edge during COMMIT: shifts into the cleared count, so bit_count=1 after COMMIT.
- row_written and row_written_addr are registered in the COMMIT cycle and visible the cycle after. frame_done follows the same timing when r = 2^ROW_BITS-1.
- Error flags:
  - err_count sets when bit_count != COLS at commit.
  - err_unblanked sets when synced blank=0 at the latch edge.
  - err_clr clears both flags; a set event in the same cycle wins.
- Shift registers are not cleared on commit. Commit correctness relies on a full reload.
- Read port: rd_pixel registered, 1-cycle latency. Reading a row during its COMMIT cycle returns the old data.
- Reset mid-row discards partial shift data; the next latch without a full COLS shifts flags err_count.

Decomposition:
- Package panel_pkg: COLS, ROW_BITS, NUM_ROWS, typedef rgb_t (logic [2:0]), typedef row_t (rgb_t [COLS-1:0]), FSM state enum rx_state_t.
- Sub-module edge_sync: parameterized SYNC_STAGES synchronizer with rising-edge pulse output; instantiated for sclk, latch, blank (blank uses level only).

Test Plan:
- Reset release, idle inputs -> all outputs 0; rd_pixel=0 for all addresses.
- 32 sclk pulses, LED_Top=3'b001 on first bit only, others 0, Row_select=2, blank=1, then latch -> row_written pulse, row_written_addr=2; rd_row=2, rd_col=31 gives 3'b001; rd_col=0 gives 0; no errors.
- Full frame rows 0..7 with LED_Bottom = row index -> frame_done single pulse after row 7; rd_row=8+i returns i at every column.
- 31 sclk pulses then latch -> err_count=1 and stays 1; err_clr -> 0; 33 pulses then latch -> err_count=1.
- Latch with blank=0 -> err_unblanked=1; err_clr asserted in the same cycle as a new violation -> flag remains 1.
- Assert reset after 16 sclk pulses, release, then 32 pulses and latch row 5 -> bit_count=32 before latch, row 5 correct, other rows 0.
